box_scene_scan: RTL and testbench

- Sequencer and nearest-hit reducer that drives the axis-aligned box intersector: one ray against a table of box objects.
- Latches one ray (origin/direction) on start and walks the object table (synchronous-read ROM, 1-cycle latency).
- Presents each 56-bit box descriptor to the intersector, waits its fixed pipeline latency, then samples t/normal.
- Keeps the closest hit and returns it to the shading stage over a valid/ready handshake.

---
 rtl/box_scene_scan.sv | 137 +++++++++++++
 tb/tb_box_scene_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/box_scene_scan.sv
// box_scene_scan
// Walks an object table for one ray, presents each box descriptor to the
// axis-aligned box intersector, waits out its pipeline latency and keeps the
// nearest hit. The result goes to the shading stage over valid/ready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, init_in, dir_in    ray request (accepted only when idle)
//   busy                      high whenever not idle
//   ray_init, ray_dir         latched ray, to the intersector
//   obj_addr, obj_rd_data     object ROM (synchronous read, 1-cycle latency)
//   obj_out                   registered descriptor, to the intersector
//   box_t, box_normal         intersector result, stable LAT cycles after obj_out
//   hit_valid, hit_ready      result handshake
//   hit_found, hit_t, hit_id, hit_normal   nearest-hit result
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; hit_* hold the previous result
// ADDR   | obj_addr stable, ROM read in flight
// LOAD   | capture ROM data into obj_out, clear wait counter
// WAIT   | LAT cycles for the intersector pipeline to settle
// SAMPLE | compare box_t against best, advance or finish
// DONE   | hit_valid high until hit_ready
module box_scene_scan #(
  parameter int          N_OBJ  = 16,
  parameter int          IDX_W  = 4,
  parameter int          LAT    = 24,
  parameter logic [9:0]  T_MISS = 10'h3FF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [27:0]      init_in,
  input  logic [30:0]      dir_in,
  output logic             busy,
  output logic [27:0]      ray_init,
  output logic [30:0]      ray_dir,
  output logic [IDX_W-1:0] obj_addr,
  input  logic [55:0]      obj_rd_data,
  output logic [55:0]      obj_out,
  input  logic [9:0]       box_t,
  input  logic [30:0]      box_normal,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic             hit_found,
  output logic [9:0]       hit_t,
  output logic [IDX_W-1:0] hit_id,
  output logic [30:0]      hit_normal
);

  localparam int               CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(LAT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // The hit_* registers double as the running best: they are cleared on
  // start, accumulate during the scan and simply hold after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      ray_init   <= '0;
      ray_dir    <= '0;
      obj_addr   <= '0;
      obj_out    <= '0;
      hit_valid  <= 1'b0;
      hit_found  <= 1'b0;
      hit_t      <= T_MISS;
      hit_id     <= '0;
      hit_normal <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ray_init   <= init_in;
            ray_dir    <= dir_in;
            obj_addr   <= '0;
            hit_found  <= 1'b0;
            hit_t      <= T_MISS;
            hit_id     <= '0;
            hit_normal <= '0;
            busy       <= 1'b1;
            state      <= S_ADDR;
          end
        end
        S_ADDR: state <= S_LOAD;
        S_LOAD: begin
          obj_out <= obj_rd_data;
          cnt     <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_END) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          // Strict less-than keeps the lower index on equal distance.
          if (box_t != T_MISS && box_t < hit_t) begin
            hit_t      <= box_t;
            hit_id     <= obj_addr;
            hit_normal <= box_normal;
            hit_found  <= 1'b1;
          end
          if (obj_addr == LAST_IDX) begin
            hit_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            obj_addr <= obj_addr + 1'b1;
            state    <= S_ADDR;
          end
        end
        S_DONE: begin
          if (hit_ready) begin
            hit_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_box_scene_scan.sv
// Bench for box_scene_scan: ROM model with 1-cycle read, intersector stub
// with an exact LAT-cycle pipeline, and a result scoreboard.
module tb_box_scene_scan;

  localparam int         N_OBJ  = 4;
  localparam int         IDX_W  = 4;
  localparam int         LAT    = 2;
  localparam logic [9:0] T_MISS = 10'h3FF;
  localparam int         PER    = LAT + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [27:0]      init_in = '0;
  logic [30:0]      dir_in = '0;
  logic             busy;
  logic [27:0]      ray_init;
  logic [30:0]      ray_dir;
  logic [IDX_W-1:0] obj_addr;
  logic [55:0]      obj_rd_data;
  logic [55:0]      obj_out;
  logic [9:0]       box_t;
  logic [30:0]      box_normal;
  logic             hit_valid;
  logic             hit_ready = 1'b0;
  logic             hit_found;
  logic [9:0]       hit_t;
  logic [IDX_W-1:0] hit_id;
  logic [30:0]      hit_normal;

  always #5 clk = ~clk;

  box_scene_scan #(.N_OBJ(N_OBJ), .IDX_W(IDX_W), .LAT(LAT), .T_MISS(T_MISS)) dut (
    .clk(clk), .rst(rst), .start(start), .init_in(init_in), .dir_in(dir_in),
    .busy(busy), .ray_init(ray_init), .ray_dir(ray_dir), .obj_addr(obj_addr),
    .obj_rd_data(obj_rd_data), .obj_out(obj_out), .box_t(box_t),
    .box_normal(box_normal), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_found(hit_found), .hit_t(hit_t), .hit_id(hit_id), .hit_normal(hit_normal)
  );

  // Descriptor layout used by the stub: [40:10] normal, [9:0] distance.
  logic [55:0] rom [16];
  always @(posedge clk) obj_rd_data <= rom[obj_addr];

  logic [55:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= obj_out;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign box_t      = pipe[LAT-1][9:0];
  assign box_normal = pipe[LAT-1][40:10];

  typedef struct {
    logic             found;
    logic [9:0]       t;
    logic [IDX_W-1:0] id;
    logic [30:0]      nrm;
    logic [27:0]      ini;
    logic [30:0]      dr;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_rom(input logic [39:0] ts);
    for (int j = 0; j < 16; j++) begin
      rom[j] = {15'($urandom), 31'($urandom), (j < N_OBJ) ? ts[j*10 +: 10] : 10'h3FF};
    end
  endtask

  function automatic exp_t model(input logic [27:0] ini, input logic [30:0] dr);
    exp_t e;
    e.found = 1'b0; e.t = T_MISS; e.id = '0; e.nrm = '0; e.ini = ini; e.dr = dr;
    for (int j = 0; j < N_OBJ; j++) begin
      if (rom[j][9:0] != T_MISS && rom[j][9:0] < e.t) begin
        e.found = 1'b1;
        e.t     = rom[j][9:0];
        e.id    = IDX_W'(j);
        e.nrm   = rom[j][40:10];
      end
    end
    return e;
  endfunction

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_busy"}, 64'(busy), 64'(0));
    chk({pfx, "_hit_valid"}, 64'(hit_valid), 64'(0));
    chk({pfx, "_hit_found"}, 64'(hit_found), 64'(0));
    chk({pfx, "_hit_t"}, 64'(hit_t), 64'(T_MISS));
    chk({pfx, "_hit_id"}, 64'(hit_id), 64'(0));
    chk({pfx, "_hit_normal"}, 64'(hit_normal), 64'(0));
    chk({pfx, "_obj_addr"}, 64'(obj_addr), 64'(0));
    chk({pfx, "_obj_out"}, 64'(obj_out), 64'(0));
    chk({pfx, "_ray_init"}, 64'(ray_init), 64'(0));
    chk({pfx, "_ray_dir"}, 64'(ray_dir), 64'(0));
  endtask

  // Period k is the interval after the k-th rising edge counted from the
  // edge that samples start (k = 0).
  task automatic run_scan(input logic [27:0] ini, input logic [30:0] dr, input int hold);
    exp_t e;
    exp_t got;
    int   cyc;
    logic [9:0]       t0;
    logic [IDX_W-1:0] id0;
    logic [30:0]      n0;
    logic             f0;
    sb.push_back(model(ini, dr));
    @(negedge clk);
    start = 1'b1; init_in = ini; dir_in = dr;
    @(negedge clk);
    start = 1'b0; init_in = ~ini; dir_in = ~dr;
    cyc = 0;
    while (hit_valid !== 1'b1 && cyc < 200) begin
      if (cyc < N_OBJ * PER) begin
        chk("scan_busy", 64'(busy), 64'(1));
        chk("obj_addr_seq", 64'(obj_addr), 64'(cyc / PER));
        if ((cyc % PER) >= 2) chk("obj_out_hold", 64'(obj_out), 64'(rom[cyc / PER]));
      end
      start = (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("hit_valid_latency", 64'(cyc), 64'(N_OBJ * PER));
    f0 = hit_found; t0 = hit_t; id0 = hit_id; n0 = hit_normal;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(hit_valid), 64'(1));
      chk("bp_busy", 64'(busy), 64'(1));
      chk("bp_stable", {hit_found, hit_t, hit_id, hit_normal}, {f0, t0, id0, n0});
    end
    got.found = hit_found; got.t = hit_t; got.id = hit_id; got.nrm = hit_normal;
    got.ini = ray_init; got.dr = ray_dir;
    e = sb.pop_front();
    chk("hit_found", 64'(got.found), 64'(e.found));
    chk("hit_t", 64'(got.t), 64'(e.t));
    chk("hit_id", 64'(got.id), 64'(e.id));
    chk("hit_normal", 64'(got.nrm), 64'(e.nrm));
    chk("ray_init", 64'(got.ini), 64'(e.ini));
    chk("ray_dir", 64'(got.dr), 64'(e.dr));
    hit_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    hit_ready = 1'b0; start = 1'b0;
    chk("ack_valid", 64'(hit_valid), 64'(0));
    chk("ack_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("start_at_ack_ignored", 64'(busy), 64'(0));
    chk("hold_after_ack", {hit_found, hit_t, hit_id, hit_normal}, {e.found, e.t, e.id, e.nrm});
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;

    set_rom({10'h060, 10'h040, 10'h080, 10'h3FF});
    run_scan(28'h1234567, 31'h1abcdef0, 10);

    set_rom({10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF});
    run_scan(28'h0fedcba, 31'h02468ace, 0);

    set_rom({10'h050, 10'h3FF, 10'h050, 10'h3FF});
    run_scan(28'h0a5a5a5, 31'h5a5a5a5a, 3);

    // Abort mid-scan: no result may ever appear.
    set_rom({10'h010, 10'h020, 10'h030, 10'h040});
    @(negedge clk);
    start = 1'b1; init_in = 28'h1111111; dir_in = 31'h2222222;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midscan_rst");
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (hit_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("no_result_after_abort", 64'(seen), 64'(0));

    run_scan(28'h0777777, 31'h33333333, 1);

    for (int r = 0; r < 3; r++) begin
      set_rom({10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
               10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))});
      run_scan(28'($urandom), 31'($urandom), r);
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
